// File: rtl/bus_arbiter.sv
// Two-master arbiter/sequencer for the shared 64-bit data-memory bus.
// Define BUS_ARB_FIXED_PRIO_EN for fixed m0 priority instead of round-robin.
module bus_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int AW      = 64,
  parameter int DW      = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_address,
  input  logic [DW-1:0] m0_WriteData,
  input  logic          m0_MemWrite,
  input  logic          m0_MemRead,
  output logic          m0_gnt,
  output logic          m0_ack,
  output logic [DW-1:0] m0_ReadData,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_address,
  input  logic [DW-1:0] m1_WriteData,
  input  logic          m1_MemWrite,
  input  logic          m1_MemRead,
  output logic          m1_gnt,
  output logic          m1_ack,
  output logic [DW-1:0] m1_ReadData,
  output logic [AW-1:0] d_address,
  output logic [DW-1:0] d_WriteData,
  output logic          d_MemWrite,
  output logic          d_MemRead,
  input  logic [DW-1:0] d_ReadData,
  output logic          busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rr_last;
  logic          owner;
  logic          rd_op;
  logic          any_req;
  logic          pick_m1;
  logic          sel_wr;
  logic          sel_rd;

  assign any_req = m0_req | m1_req;

`ifdef BUS_ARB_FIXED_PRIO_EN
  assign pick_m1 = m1_req & ~m0_req;
`else
  assign pick_m1 = m1_req & (~m0_req | ~rr_last);
`endif

  assign sel_wr = pick_m1 ? m1_MemWrite : m0_MemWrite;
  assign sel_rd = pick_m1 ? m1_MemRead : m0_MemRead;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rr_last     <= 1'b1;
      owner       <= 1'b0;
      rd_op       <= 1'b0;
      d_address   <= '0;
      d_WriteData <= '0;
      d_MemWrite  <= 1'b0;
      d_MemRead   <= 1'b0;
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_ReadData <= '0;
      m1_ReadData <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner       <= pick_m1;
            rr_last     <= pick_m1;
            d_address   <= pick_m1 ? m1_address : m0_address;
            d_WriteData <= pick_m1 ? m1_WriteData : m0_WriteData;
            rd_op       <= sel_rd & ~sel_wr;
            d_MemWrite  <= sel_wr;
            d_MemRead   <= sel_rd & ~sel_wr;
            m0_gnt      <= ~pick_m1;
            m1_gnt      <= pick_m1;
            cnt         <= CW'(MEM_LAT - 1);
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            // read data is only valid in the last access cycle
            if (rd_op) begin
              if (owner) m1_ReadData <= d_ReadData;
              else       m0_ReadData <= d_ReadData;
            end
            d_MemWrite <= 1'b0;
            d_MemRead  <= 1'b0;
            m0_ack     <= ~owner;
            m1_ack     <= owner;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          m0_gnt <= 1'b0;
          m1_gnt <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (MEM_LAT=1 and 3) against a
// transaction-level model of arbitration order, timing and read data.
module tb_bus_arbiter;

  typedef struct packed {
    logic        req;
    logic [63:0] a;
    logic [63:0] wd;
    logic        wr;
    logic        rd;
  } mreq_t;

  logic        clk = 1'b0;
  logic        reset        [2];
  logic        m0_req       [2];
  logic [63:0] m0_address   [2];
  logic [63:0] m0_WriteData [2];
  logic        m0_MemWrite  [2];
  logic        m0_MemRead   [2];
  logic        m0_gnt       [2];
  logic        m0_ack       [2];
  logic [63:0] m0_ReadData  [2];
  logic        m1_req       [2];
  logic [63:0] m1_address   [2];
  logic [63:0] m1_WriteData [2];
  logic        m1_MemWrite  [2];
  logic        m1_MemRead   [2];
  logic        m1_gnt       [2];
  logic        m1_ack       [2];
  logic [63:0] m1_ReadData  [2];
  logic [63:0] d_address    [2];
  logic [63:0] d_WriteData  [2];
  logic        d_MemWrite   [2];
  logic        d_MemRead    [2];
  logic [63:0] d_ReadData   [2];
  logic        busy         [2];

  int          checks = 0;
  int          errors = 0;
  int          exp_rr [2];
  logic [63:0] exp_rd0 [2];
  logic [63:0] exp_rd1 [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bus_arbiter #(
      .MEM_LAT(g == 0 ? 1 : 3),
      .AW(64),
      .DW(64)
    ) u_dut (
      .clk(clk),
      .reset(reset[g]),
      .m0_req(m0_req[g]),
      .m0_address(m0_address[g]),
      .m0_WriteData(m0_WriteData[g]),
      .m0_MemWrite(m0_MemWrite[g]),
      .m0_MemRead(m0_MemRead[g]),
      .m0_gnt(m0_gnt[g]),
      .m0_ack(m0_ack[g]),
      .m0_ReadData(m0_ReadData[g]),
      .m1_req(m1_req[g]),
      .m1_address(m1_address[g]),
      .m1_WriteData(m1_WriteData[g]),
      .m1_MemWrite(m1_MemWrite[g]),
      .m1_MemRead(m1_MemRead[g]),
      .m1_gnt(m1_gnt[g]),
      .m1_ack(m1_ack[g]),
      .m1_ReadData(m1_ReadData[g]),
      .d_address(d_address[g]),
      .d_WriteData(d_WriteData[g]),
      .d_MemWrite(d_MemWrite[g]),
      .d_MemRead(d_MemRead[g]),
      .d_ReadData(d_ReadData[g]),
      .busy(busy[g])
    );
  end

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic mreq_t mk(input logic r, input logic [63:0] a,
                               input logic [63:0] wd, input logic wr,
                               input logic rd);
    mreq_t q;
    q.req = r; q.a = a; q.wd = wd; q.wr = wr; q.rd = rd;
    return q;
  endfunction

  function automatic int pick(input int k, input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef BUS_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (exp_rr[k] == 1) ? 0 : 1;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  function automatic logic [6:0] vec(input int k);
    return {m0_gnt[k], m1_gnt[k], d_MemWrite[k], d_MemRead[k],
            busy[k], m0_ack[k], m1_ack[k]};
  endfunction

  task automatic set_in(input int k, input mreq_t q0, input mreq_t q1);
    m0_req[k] = q0.req; m0_address[k] = q0.a; m0_WriteData[k] = q0.wd;
    m0_MemWrite[k] = q0.wr; m0_MemRead[k] = q0.rd;
    m1_req[k] = q1.req; m1_address[k] = q1.a; m1_WriteData[k] = q1.wd;
    m1_MemWrite[k] = q1.wr; m1_MemRead[k] = q1.rd;
  endtask

  task automatic model_reset(input int k);
    exp_rr[k] = 1;
    exp_rd0[k] = '0;
    exp_rd1[k] = '0;
  endtask

  task automatic run_txn(input int k, input mreq_t q0, input mreq_t q1,
                         input logic [63:0] mem, input bit drop,
                         input bit scramble);
    int own;
    int L;
    logic ewr, erd;
    logic [63:0] ea, ewd;
    logic [6:0] ev;
    mreq_t z;
    L = lat(k);
    z = '0;
    @(negedge clk);
    set_in(k, q0, q1);
    d_ReadData[k] = mem;
    if (!q0.req && !q1.req) begin
      @(negedge clk);
      checks++;
      if (vec(k) !== 7'b0) begin
        errors++;
        $display("FAIL idle_noreq k=%0d got %b exp 0", k, vec(k));
      end
      return;
    end
    own = pick(k, q0.req, q1.req);
    exp_rr[k] = own;
    ea  = own ? q1.a : q0.a;
    ewd = own ? q1.wd : q0.wd;
    ewr = own ? q1.wr : q0.wr;
    erd = (own ? q1.rd : q0.rd) & ~ewr;
    for (int c = 1; c <= L; c++) begin
      @(negedge clk);
      if (c == 1 && (drop || scramble)) begin
        z = mk(!drop, {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom), 1'($urandom));
        if (own == 1) set_in(k, q0, z);
        else          set_in(k, z, q1);
      end
      ev = {own == 0, own == 1, ewr, erd, 1'b1, 1'b0, 1'b0};
      checks++;
      if (vec(k) !== ev) begin
        errors++;
        $display("FAIL access_ctl k=%0d c=%0d got %b exp %b", k, c, vec(k), ev);
      end
      checks++;
      if (d_address[k] !== ea || d_WriteData[k] !== ewd) begin
        errors++;
        $display("FAIL access_bus k=%0d got %h/%h exp %h/%h", k,
                 d_address[k], d_WriteData[k], ea, ewd);
      end
      checks++;
      if (m0_ReadData[k] !== exp_rd0[k] || m1_ReadData[k] !== exp_rd1[k]) begin
        errors++;
        $display("FAIL access_rdata k=%0d got %h/%h exp %h/%h", k,
                 m0_ReadData[k], m1_ReadData[k], exp_rd0[k], exp_rd1[k]);
      end
    end
    if (erd) begin
      if (own == 1) exp_rd1[k] = mem;
      else          exp_rd0[k] = mem;
    end
    @(negedge clk);
    ev = {own == 0, own == 1, 1'b0, 1'b0, 1'b1, own == 0, own == 1};
    checks++;
    if (vec(k) !== ev) begin
      errors++;
      $display("FAIL resp_ctl k=%0d got %b exp %b", k, vec(k), ev);
    end
    checks++;
    if (m0_ReadData[k] !== exp_rd0[k] || m1_ReadData[k] !== exp_rd1[k]) begin
      errors++;
      $display("FAIL resp_rdata k=%0d got %h/%h exp %h/%h", k,
               m0_ReadData[k], m1_ReadData[k], exp_rd0[k], exp_rd1[k]);
    end
    z = '0;
    set_in(k, z, z);
    @(negedge clk);
    checks++;
    if (vec(k) !== 7'b0 || d_address[k] !== ea) begin
      errors++;
      $display("FAIL post_idle k=%0d got %b/%h exp 0/%h", k, vec(k),
               d_address[k], ea);
    end
  endtask

  task automatic test_reset(input int k);
    mreq_t z;
    z = '0;
    @(negedge clk);
    reset[k] = 1'b1;
    set_in(k, z, z);
    @(negedge clk);
    reset[k] = 1'b0;
    model_reset(k);
    checks++;
    if (vec(k) !== 7'b0 || d_address[k] !== '0 || d_WriteData[k] !== '0 ||
        m0_ReadData[k] !== '0 || m1_ReadData[k] !== '0) begin
      errors++;
      $display("FAIL reset_state k=%0d got %b exp 0", k, vec(k));
    end
  endtask

  task automatic test_read_lat1();
    run_txn(0, mk(1, 64'h100, 64'h0, 0, 1), '0,
            64'hDEADBEEF_CAFEF00D, 0, 0);
    checks++;
    if (m0_ReadData[0] !== 64'hDEADBEEF_CAFEF00D) begin
      errors++;
      $display("FAIL read_lat1 got %h exp deadbeefcafef00d", m0_ReadData[0]);
    end
  endtask

  task automatic test_write_lat3();
    logic [63:0] old1;
    old1 = m1_ReadData[1];
    run_txn(1, '0, mk(1, 64'h40, 64'h1234, 1, 0), 64'h5555, 0, 0);
    checks++;
    if (m1_ReadData[1] !== old1) begin
      errors++;
      $display("FAIL write_keeps_rdata got %h exp %h", m1_ReadData[1], old1);
    end
  endtask

  task automatic test_rw_noop(input int k);
    run_txn(k, mk(1, 64'h200, 64'hABCD, 1, 1), '0, 64'h1111, 0, 0);
    run_txn(k, mk(1, 64'h300, 64'h0, 0, 1), '0, 64'h2222, 0, 0);
    run_txn(k, mk(1, 64'h308, 64'h0, 0, 0), '0, 64'h3333, 0, 0);
  endtask

  task automatic test_drop(input int k);
    run_txn(k, mk(1, 64'h500, 64'h77, 0, 1), '0, 64'h4444, 1, 0);
  endtask

  task automatic test_back_to_back(input int k);
    int L, own;
    logic [63:0] mem, ea;
    logic [6:0] ev;
    mreq_t q0, q1, z;
    L = lat(k);
    mem = {$urandom, $urandom};
    q0 = mk(1, 64'hA00, 64'h0, 0, 1);
    q1 = mk(1, 64'hB00, 64'h99, 1, 0);
    z = '0;
    @(negedge clk);
    set_in(k, q0, q1);
    d_ReadData[k] = mem;
    for (int t = 0; t < 6; t++) begin
      own = pick(k, 1'b1, 1'b1);
      exp_rr[k] = own;
      ea = own ? q1.a : q0.a;
      for (int c = 1; c <= L; c++) begin
        @(negedge clk);
        ev = {own == 0, own == 1, own == 1, own == 0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (vec(k) !== ev || d_address[k] !== ea) begin
          errors++;
          $display("FAIL b2b_access k=%0d t=%0d got %b exp %b", k, t, vec(k), ev);
        end
      end
      if (own == 0) exp_rd0[k] = mem;
      @(negedge clk);
      ev = {own == 0, own == 1, 1'b0, 1'b0, 1'b1, own == 0, own == 1};
      checks++;
      if (vec(k) !== ev || m0_ReadData[k] !== exp_rd0[k]) begin
        errors++;
        $display("FAIL b2b_resp k=%0d t=%0d got %b exp %b", k, t, vec(k), ev);
      end
      if (t == 5) set_in(k, z, z);
      @(negedge clk);
      checks++;
      if (vec(k) !== 7'b0) begin
        errors++;
        $display("FAIL b2b_idle k=%0d t=%0d got %b exp 0", k, t, vec(k));
      end
    end
  endtask

  task automatic test_reset_mid();
    mreq_t z;
    z = '0;
    @(negedge clk);
    set_in(1, mk(1, 64'h800, 64'h0, 0, 1), z);
    d_ReadData[1] = 64'hFEED;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (d_MemRead[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_access got %b exp 1", d_MemRead[1]);
    end
    reset[1] = 1'b1;
    set_in(1, z, z);
    @(negedge clk);
    reset[1] = 1'b0;
    model_reset(1);
    checks++;
    if (vec(1) !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset got %b exp 0", vec(1));
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (vec(1) !== 7'b0) begin
        errors++;
        $display("FAIL no_ack_after_reset i=%0d got %b exp 0", i, vec(1));
      end
    end
    run_txn(1, mk(1, 64'h808, 64'h0, 0, 1), z, 64'hC0FFEE, 0, 0);
  endtask

  task automatic test_random(input int k, input int n);
    mreq_t q0, q1;
    for (int i = 0; i < n; i++) begin
      q0 = mk(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom), 1'($urandom));
      q1 = mk(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom), 1'($urandom));
      run_txn(k, q0, q1, {$urandom, $urandom},
              ($urandom_range(0, 3) == 0), 1'($urandom));
    end
  endtask

  initial begin
    mreq_t z;
    z = '0;
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1;
      set_in(k, z, z);
      d_ReadData[k] = '0;
      model_reset(k);
    end
    test_reset(0);
    test_reset(1);
    test_read_lat1();
    test_write_lat3();
    test_rw_noop(0);
    test_rw_noop(1);
    test_drop(0);
    test_drop(1);
    test_back_to_back(0);
    test_back_to_back(1);
    test_reset_mid();
    test_random(0, 60);
    test_random(1, 60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
